// File: rtl/ula_seq_if.sv
// ula_seq_if: bundles the sequencer's operation input, its link to the
// nibble-wide ula core, and its result output.
//   slave  : the sequencer's view
//   master : the environment's view (operation source, ula core, result sink)
interface ula_seq_if #(
    parameter int NIB   = 4,
    parameter int NWORD = 4
);
    localparam int W = NIB * NWORD;

    // operation input
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_a_inv;
    logic           in_b_inv;
    logic           in_c_in;
    logic [1:0]     in_alu_op;
    logic           in_chain;

    // link to the ula core
    logic [NIB-1:0] u_a;
    logic [NIB-1:0] u_b;
    logic           u_a_inv;
    logic           u_b_inv;
    logic           u_c_in;
    logic [1:0]     u_alu_op;
    logic [NIB-1:0] u_out;
    logic           u_N;
    logic           u_C;
    logic           u_V;
    logic           u_Z;

    // result output
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_result;
    logic           out_N;
    logic           out_C;
    logic           out_V;
    logic           out_Z;

    modport slave (
        input  in_valid, in_a, in_b, in_a_inv, in_b_inv, in_c_in, in_alu_op, in_chain,
        output in_ready,
        output u_a, u_b, u_a_inv, u_b_inv, u_c_in, u_alu_op,
        input  u_out, u_N, u_C, u_V, u_Z,
        output out_valid, out_result, out_N, out_C, out_V, out_Z,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_a_inv, in_b_inv, in_c_in, in_alu_op, in_chain,
        input  in_ready,
        input  u_a, u_b, u_a_inv, u_b_inv, u_c_in, u_alu_op,
        output u_out, u_N, u_C, u_V, u_Z,
        input  out_valid, out_result, out_N, out_C, out_V, out_Z,
        output out_ready
    );
endinterface

// File: rtl/ula_seq.sv
// ula_seq: nibble-serial sequencer in front of the combinational ula core.
// Accepts one W-bit operation, walks it through the ula one nibble per clock
// (LSB nibble first) chaining carries, then holds the assembled result and
// aggregate N/C/V/Z until the consumer takes it.
// Optional feature: define ULA_SEQ_B2B_EN to accept the next operation on the
// same edge the current result is transferred out.
module ula_seq #(
    parameter int NIB   = 4,
    parameter int NWORD = 4
) (
    input  logic        clk,
    input  logic        rst,
    ula_seq_if.slave    bus
);
    localparam int W  = NIB * NWORD;
    localparam int IW = (NWORD > 1) ? $clog2(NWORD) : 1;
    localparam logic [IW-1:0] LAST = IW'(NWORD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           load;
    logic           run;
    logic           last;

    // operand shifters: the current nibble always sits in the low NIB bits
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic           a_inv_r;
    logic           b_inv_r;
    logic           c_in_r;
    logic           chain_r;
    logic [1:0]     op_r;

    logic [IW-1:0]  idx;
    logic           carry_r;
    logic           zacc;

    logic [W-1:0]   res_r;
    logic           n_r;
    logic           c_r;
    logic           v_r;
    logic           z_r;

    assign run  = (state == RUN);
    assign last = (idx == LAST);

    // next-state and handshake decode
    always_comb begin
        state_nxt     = state;
        load          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last)
                    state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
`ifdef ULA_SEQ_B2B_EN
                // a new operation may only enter when the old result leaves
                bus.in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
`else
                if (bus.out_ready)
                    state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // operand capture, per-nibble accumulation and final flag latch
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            a_inv_r <= 1'b0;
            b_inv_r <= 1'b0;
            c_in_r  <= 1'b0;
            chain_r <= 1'b0;
            op_r    <= '0;
            idx     <= '0;
            carry_r <= 1'b0;
            zacc    <= 1'b1;
            res_r   <= '0;
            n_r     <= 1'b0;
            c_r     <= 1'b0;
            v_r     <= 1'b0;
            z_r     <= 1'b0;
        end else if (load) begin
            a_sh    <= bus.in_a;
            b_sh    <= bus.in_b;
            a_inv_r <= bus.in_a_inv;
            b_inv_r <= bus.in_b_inv;
            c_in_r  <= bus.in_c_in;
            chain_r <= bus.in_chain;
            op_r    <= bus.in_alu_op;
            idx     <= '0;
            carry_r <= bus.in_c_in;
            zacc    <= 1'b1;
        end else if (run) begin
            a_sh    <= a_sh >> NIB;
            b_sh    <= b_sh >> NIB;
            // result fills from the top; after NWORD nibbles nibble 0 is at the bottom
            res_r   <= {bus.u_out, res_r[W-1:NIB]};
            carry_r <= bus.u_C;
            zacc    <= zacc & bus.u_Z;
            idx     <= idx + IW'(1);
            if (last) begin
                n_r <= bus.u_N;
                c_r <= bus.u_C;
                v_r <= bus.u_V;
                z_r <= zacc & bus.u_Z;
            end
        end
    end

    // ula drive: registers only, held at zero outside RUN
    assign bus.u_a      = run ? a_sh[NIB-1:0] : '0;
    assign bus.u_b      = run ? b_sh[NIB-1:0] : '0;
    assign bus.u_a_inv  = run & a_inv_r;
    assign bus.u_b_inv  = run & b_inv_r;
    assign bus.u_alu_op = run ? op_r : 2'b00;
    assign bus.u_c_in   = run & (((idx == '0) || !chain_r) ? c_in_r : carry_r);

    assign bus.out_result = res_r;
    assign bus.out_N      = n_r;
    assign bus.out_C      = c_r;
    assign bus.out_V      = v_r;
    assign bus.out_Z      = z_r;
endmodule
